// File: rtl/vga_scanout_reader_if.sv
// VideoMemory read port as seen by the scanout reader (master) and the memory (slave).
interface vga_scanout_reader_if #(
  parameter int ADDR_WIDTH = 24
);
  logic [ADDR_WIDTH-1:0] oReadAddress;
  logic [2:0]            iReadData;

  modport master (output oReadAddress, input  iReadData);
  modport slave  (input  oReadAddress, output iReadData);
endinterface

// File: rtl/vga_scanout_reader.sv
// 640x480@60 raster scanout of VideoMemory: 25 MHz pixel tick from Clock, linear read address, registered RGB/sync.
// Build option VGA_TEST_PATTERN_EN adds iTestPattern, replacing visible pixels with 64-px colour bars.
module vga_scanout_reader #(
  parameter int H_VISIBLE  = 640,
  parameter int H_FRONT    = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BACK     = 48,
  parameter int V_VISIBLE  = 480,
  parameter int V_FRONT    = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BACK     = 33,
  parameter int ADDR_WIDTH = 24
) (
  input  logic                 Clock,
  input  logic                 Reset,
  vga_scanout_reader_if.master mem,
`ifdef VGA_TEST_PATTERN_EN
  input  logic                 iTestPattern,
`endif
  output logic                 oVGA_HSYNC,
  output logic                 oVGA_VSYNC,
  output logic                 oVGA_RED,
  output logic                 oVGA_GREEN,
  output logic                 oVGA_BLUE,
  output logic                 oFrameStart
);
  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_VIS    = HW'(H_VISIBLE);
  localparam logic [HW-1:0] HS_START = HW'(H_VISIBLE + H_FRONT);
  localparam logic [HW-1:0] HS_END   = HW'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_VIS    = VW'(V_VISIBLE);
  localparam logic [VW-1:0] VS_START = VW'(V_VISIBLE + V_FRONT);
  localparam logic [VW-1:0] VS_END   = VW'(V_VISIBLE + V_FRONT + V_SYNC - 1);

  logic                  rPixelEn;
  logic [HW-1:0]         rH;
  logic [VW-1:0]         rV;
  logic [ADDR_WIDTH-1:0] rReadAddress;

  logic       visible, hSyncN, vSyncN, lineEnd, frameEnd;
  logic [2:0] pixel;

  // Everything below describes the position being left on this tick; the
  // memory word for it was read one Clock after its address was issued.
  always_comb begin
    visible  = (rH < H_VIS) && (rV < V_VIS);
    hSyncN   = !((rH >= HS_START) && (rH <= HS_END));
    vSyncN   = !((rV >= VS_START) && (rV <= VS_END));
    lineEnd  = (rH == H_LAST);
    frameEnd = lineEnd && (rV == V_LAST);
    pixel    = 3'b000;
    if (visible) begin
`ifdef VGA_TEST_PATTERN_EN
      pixel = iTestPattern ? 3'(32'(rH) >> 6) : mem.iReadData;
`else
      pixel = mem.iReadData;
`endif
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      rPixelEn     <= 1'b0;
      rH           <= '0;
      rV           <= '0;
      rReadAddress <= '0;
      oVGA_HSYNC   <= 1'b1;
      oVGA_VSYNC   <= 1'b1;
      oVGA_RED     <= 1'b0;
      oVGA_GREEN   <= 1'b0;
      oVGA_BLUE    <= 1'b0;
      oFrameStart  <= 1'b0;
    end else begin
      rPixelEn    <= !rPixelEn;
      oFrameStart <= 1'b0;
      if (rPixelEn) begin
        oVGA_HSYNC  <= hSyncN;
        oVGA_VSYNC  <= vSyncN;
        oVGA_RED    <= pixel[2];
        oVGA_GREEN  <= pixel[1];
        oVGA_BLUE   <= pixel[0];
        oFrameStart <= frameEnd;

        if (lineEnd) begin
          rH <= '0;
          rV <= frameEnd ? '0 : rV + VW'(1);
        end else begin
          rH <= rH + HW'(1);
        end

        // Counting visible pixels keeps the address equal to rV*H_VISIBLE+rH without a multiplier.
        if (frameEnd)
          rReadAddress <= '0;
        else if (visible)
          rReadAddress <= rReadAddress + ADDR_WIDTH'(1);
      end
    end
  end

  assign mem.oReadAddress = rReadAddress;

endmodule

// File: tb/tb_vga_scanout_reader.sv
// Scoreboard bench for vga_scanout_reader on a shrunken raster so whole frames fit in a short run.
module tb_vga_scanout_reader;
`ifdef VGA_TEST_PATTERN_EN
  localparam int HV = 512, HF = 8, HS = 16, HB = 8;
  localparam int VV = 4,   VF = 1, VS = 1,  VB = 1;
`else
  localparam int HV = 16,  HF = 2, HS = 4,  HB = 3;
  localparam int VV = 8,   VF = 1, VS = 2,  VB = 2;
`endif
  localparam int AW       = 24;
  localparam int HT       = HV + HF + HS + HB;
  localparam int VT       = VV + VF + VS + VB;
  localparam int HS_START = HV + HF;
  localparam int HS_END   = HS_START + HS - 1;
  localparam int VS_START = VV + VF;
  localparam int VS_END   = VS_START + VS - 1;

  logic Clock = 1'b0;
  logic Reset = 1'b0;
  logic oVGA_HSYNC, oVGA_VSYNC, oVGA_RED, oVGA_GREEN, oVGA_BLUE, oFrameStart;
`ifdef VGA_TEST_PATTERN_EN
  logic iTestPattern = 1'b0;
`endif

  vga_scanout_reader_if #(.ADDR_WIDTH(AW)) mem ();

  vga_scanout_reader #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .ADDR_WIDTH(AW)
  ) dut (
    .Clock       (Clock),
    .Reset       (Reset),
    .mem         (mem),
`ifdef VGA_TEST_PATTERN_EN
    .iTestPattern(iTestPattern),
`endif
    .oVGA_HSYNC  (oVGA_HSYNC),
    .oVGA_VSYNC  (oVGA_VSYNC),
    .oVGA_RED    (oVGA_RED),
    .oVGA_GREEN  (oVGA_GREEN),
    .oVGA_BLUE   (oVGA_BLUE),
    .oFrameStart (oFrameStart)
  );

  always #10 Clock = ~Clock;

  // Synchronous video memory whose contents are the low address bits.
  always @(posedge Clock) mem.iReadData <= mem.oReadAddress[2:0];

  typedef struct packed {
    logic       hs;
    logic       vs;
    logic [2:0] rgb;
    logic       fs;
  } exp_t;

  exp_t sbq[$];
  int   checks   = 0;
  int   failures = 0;
  int   mx = 0, my = 0, relClk = 0;
  bit   phase = 1'b0;

  function automatic int exp_addr(int x, int y);
    if (y >= VV) return VV * HV;
    return y * HV + ((x < HV) ? x : HV);
  endfunction

  function automatic exp_t exp_out(int x, int y, bit pat);
    exp_t e;
    int   a;
    a     = y * HV + x;
    e.hs  = !(x >= HS_START && x <= HS_END);
    e.vs  = !(y >= VS_START && y <= VS_END);
    e.fs  = (x == HT - 1) && (y == VT - 1);
    e.rgb = 3'b000;
    if (x < HV && y < VV) e.rgb = pat ? 3'(x >> 6) : 3'(a);
    return e;
  endfunction

  function automatic logic [5:0] dut_out();
    return {oVGA_HSYNC, oVGA_VSYNC, oVGA_RED, oVGA_GREEN, oVGA_BLUE, oFrameStart};
  endfunction

  // One Clock; every second edge after release is a pixel tick that advances the model position.
  task automatic clk_step();
    @(posedge Clock); #1;
    relClk++;
    phase = !phase;
    if (!phase) begin
      if (mx == HT - 1) begin
        mx = 0;
        my = (my == VT - 1) ? 0 : my + 1;
      end else begin
        mx++;
      end
    end
  endtask

  task automatic release_reset();
    @(negedge Clock);
    Reset  = 1'b1;
    phase  = 1'b0;
    mx     = 0;
    my     = 0;
    relClk = 0;
  endtask

  task automatic seek(input int x, input int y, input bit anyLine, input string tag);
    int guard = 0;
    while (!(mx == x && (anyLine || my == y) && phase == 1'b0) && guard < 4 * HT * VT) begin
      clk_step();
      guard++;
    end
    checks++;
    if (guard >= 4 * HT * VT) begin
      failures++;
      $display("FAIL %s_seek timeout got x=%0d y=%0d exp x=%0d y=%0d", tag, mx, my, x, y);
    end
  endtask

  task automatic test_reset();
    Reset = 1'b0;
    repeat (10) begin
      @(posedge Clock); #1;
      checks++;
      if (dut_out() !== 6'b110000) begin
        failures++;
        $display("FAIL reset_outputs got=%b exp=110000", dut_out());
      end
      checks++;
      if (mem.oReadAddress !== '0) begin
        failures++;
        $display("FAIL reset_addr got=%0d exp=0", mem.oReadAddress);
      end
    end
    release_reset();
  endtask

  task automatic test_raster();
    exp_t e, held;
    int   firstFs = -1;
    int   x, y;
    held = exp_t'(6'b110000);
    for (int n = 0; n < HT * VT + HT; n++) begin
      x = mx;
      y = my;
      checks++;
      if (mem.oReadAddress !== AW'(exp_addr(x, y))) begin
        failures++;
        $display("FAIL raster_addr x=%0d y=%0d got=%0d exp=%0d", x, y, mem.oReadAddress, exp_addr(x, y));
      end
      sbq.push_back(exp_out(x, y, 1'b0));
      clk_step();
      checks++;
      if (dut_out() !== {held.hs, held.vs, held.rgb, 1'b0}) begin
        failures++;
        $display("FAIL raster_hold x=%0d y=%0d got=%b exp=%b", x, y, dut_out(), {held.hs, held.vs, held.rgb, 1'b0});
      end
      clk_step();
      e = sbq.pop_front();
      if (oFrameStart === 1'b1 && firstFs < 0) firstFs = relClk;
      checks++;
      if (dut_out() !== 6'(e)) begin
        failures++;
        $display("FAIL raster_pixel x=%0d y=%0d got=%b exp=%b", x, y, dut_out(), 6'(e));
      end
      held = e;
    end
    checks++;
    if (firstFs !== 2 * HT * VT) begin
      failures++;
      $display("FAIL first_framestart got=%0d exp=%0d clocks", firstFs, 2 * HT * VT);
    end
  endtask

  task automatic test_addr_bookkeeping();
    int guard = 0;
    seek(HV, 0, 1'b0, "bookkeeping");
    for (int x = HV; x < HT; x++) begin
      checks++;
      if (mem.oReadAddress !== AW'(HV)) begin
        failures++;
        $display("FAIL blank_addr_hold x=%0d got=%0d exp=%0d", x, mem.oReadAddress, HV);
      end
      clk_step();
      clk_step();
    end
    while (oFrameStart !== 1'b1 && guard < 4 * HT * VT) begin
      clk_step();
      guard++;
    end
    checks++;
    if (oFrameStart !== 1'b1 || mem.oReadAddress !== '0) begin
      failures++;
      $display("FAIL framestart_addr got fs=%b addr=%0d exp fs=1 addr=0", oFrameStart, mem.oReadAddress);
    end
  endtask

  task automatic test_line_timing();
    int   t = 0, f1 = -1, r1 = -1, f2 = -1;
    logic prev;
    seek(0, 0, 1'b1, "line");
    prev = oVGA_HSYNC;
    for (int i = 0; i < 4 * HT + 8 && f2 < 0; i++) begin
      clk_step();
      t++;
      if (prev === 1'b1 && oVGA_HSYNC === 1'b0) begin
        if (f1 < 0) f1 = t; else f2 = t;
      end
      if (prev === 1'b0 && oVGA_HSYNC === 1'b1 && f1 >= 0 && r1 < 0) r1 = t;
      prev = oVGA_HSYNC;
    end
    checks++;
    if (f1 !== 2 * (HS_START + 1)) begin
      failures++;
      $display("FAIL hsync_fall_offset got=%0d exp=%0d", f1, 2 * (HS_START + 1));
    end
    checks++;
    if (r1 - f1 !== 2 * HS) begin
      failures++;
      $display("FAIL hsync_low_width got=%0d exp=%0d", r1 - f1, 2 * HS);
    end
    checks++;
    if (f2 - f1 !== 2 * HT) begin
      failures++;
      $display("FAIL hsync_period got=%0d exp=%0d", f2 - f1, 2 * HT);
    end
  endtask

  task automatic test_frame_timing();
    int   t = 0, f1 = -1, r1 = -1, f2 = -1;
    logic prev;
    seek(0, 0, 1'b0, "frame");
    prev = oVGA_VSYNC;
    for (int i = 0; i < 4 * HT * VT + 8 && f2 < 0; i++) begin
      clk_step();
      t++;
      if (prev === 1'b1 && oVGA_VSYNC === 1'b0) begin
        if (f1 < 0) f1 = t; else f2 = t;
      end
      if (prev === 1'b0 && oVGA_VSYNC === 1'b1 && f1 >= 0 && r1 < 0) r1 = t;
      prev = oVGA_VSYNC;
    end
    checks++;
    if (f1 !== 2 * (VS_START * HT + 1)) begin
      failures++;
      $display("FAIL vsync_fall_offset got=%0d exp=%0d", f1, 2 * (VS_START * HT + 1));
    end
    checks++;
    if (r1 - f1 !== 2 * VS * HT) begin
      failures++;
      $display("FAIL vsync_low_width got=%0d exp=%0d", r1 - f1, 2 * VS * HT);
    end
    checks++;
    if (f2 - f1 !== 2 * HT * VT) begin
      failures++;
      $display("FAIL vsync_period got=%0d exp=%0d", f2 - f1, 2 * HT * VT);
    end
  endtask

`ifdef VGA_TEST_PATTERN_EN
  task automatic test_pattern();
    exp_t e;
    int   x, y;
    iTestPattern = 1'b1;
    seek(0, 1, 1'b0, "pattern");
    for (int n = 0; n < HT; n++) begin
      x = mx;
      y = my;
      checks++;
      if (mem.oReadAddress !== AW'(exp_addr(x, y))) begin
        failures++;
        $display("FAIL pattern_addr x=%0d got=%0d exp=%0d", x, mem.oReadAddress, exp_addr(x, y));
      end
      sbq.push_back(exp_out(x, y, 1'b1));
      clk_step();
      clk_step();
      e = sbq.pop_front();
      checks++;
      if (dut_out() !== 6'(e)) begin
        failures++;
        $display("FAIL pattern_pixel x=%0d got=%b exp=%b", x, dut_out(), 6'(e));
      end
    end
    iTestPattern = 1'b0;
  endtask
`endif

  task automatic test_reset_midframe();
    exp_t e;
    int   x;
    seek(HV / 2, VV / 2, 1'b0, "midframe");
    #2 Reset = 1'b0;
    #1;
    checks++;
    if (dut_out() !== 6'b110000 || mem.oReadAddress !== '0) begin
      failures++;
      $display("FAIL midframe_async_reset got out=%b addr=%0d exp out=110000 addr=0", dut_out(), mem.oReadAddress);
    end
    repeat (3) begin
      @(posedge Clock); #1;
      checks++;
      if (dut_out() !== 6'b110000 || mem.oReadAddress !== '0) begin
        failures++;
        $display("FAIL midframe_reset_hold got out=%b addr=%0d exp out=110000 addr=0", dut_out(), mem.oReadAddress);
      end
    end
    release_reset();
    for (int n = 0; n < 8; n++) begin
      x = mx;
      checks++;
      if (mem.oReadAddress !== AW'(x)) begin
        failures++;
        $display("FAIL restart_addr x=%0d got=%0d exp=%0d", x, mem.oReadAddress, x);
      end
      sbq.push_back(exp_out(x, 0, 1'b0));
      clk_step();
      clk_step();
      e = sbq.pop_front();
      checks++;
      if (dut_out() !== 6'(e)) begin
        failures++;
        $display("FAIL restart_pixel x=%0d got=%b exp=%b", x, dut_out(), 6'(e));
      end
    end
  endtask

  initial begin
    test_reset();
    test_raster();
    test_addr_bookkeeping();
    test_line_timing();
    test_frame_timing();
`ifdef VGA_TEST_PATTERN_EN
    test_pattern();
`endif
    test_reset_midframe();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vga_scanout_reader.md
Name: vga_scanout_reader

Overview:
- Read-side counterpart to the MiniAlu VGA write path. MiniAlu writes 3-bit RGB pixels into VideoMemory; this block reads them back out.
- Generates 640x480@60 Hz timing from the 50 MHz system clock and scans the video memory read port in raster order, one address per pixel.
- Drives registered, sync-aligned RGB and HSYNC/VSYNC to the board VGA pins, blanking outside the visible area.
- Replaces the free-running VGA_SYNC instance as the consumer of the VideoMemory read port.

Parameters:
- H_VISIBLE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch in pixels
- H_SYNC, 96, horizontal sync width in pixels
- H_BACK, 48, horizontal back porch in pixels
- V_VISIBLE, 480, visible lines per frame
- V_FRONT, 10, vertical front porch in lines
- V_SYNC, 2, vertical sync width in lines
- V_BACK, 33, vertical back porch in lines
- ADDR_WIDTH, 24, video memory read address width

Ports:
- Clock  input  1  system clock, 50 MHz
- Reset  input  1  asynchronous, active-low reset
- oReadAddress  output  ADDR_WIDTH  linear pixel address to VideoMemory read port
- iReadData  input  3  {R,G,B} from VideoMemory; valid one Clock after address
- oVGA_HSYNC  output  1  horizontal sync, active low
- oVGA_VSYNC  output  1  vertical sync, active low
- oVGA_RED  output  1  red pixel
- oVGA_GREEN  output  1  green pixel
- oVGA_BLUE  output  1  blue pixel
- oFrameStart  output  1  one-Clock pulse at the start of each frame

Behaviour:
- Reset values (Reset low, asynchronous):
  - rPixelEn=0, rH=0, rV=0, oReadAddress=0
  - oVGA_HSYNC=1, oVGA_VSYNC=1, RGB=000, oFrameStart=0
- Pixel tick: rPixelEn toggles every Clock, giving a 25 MHz tick. All counter and output updates occur only on Clock edges where rPixelEn=1. The first tick after reset release is the second Clock edge.
- Horizontal counter rH:
  - Range 0..H_TOTAL-1, where H_TOTAL = sum of H params = 800.
  - Wraps to 0 and increments rV.
- Vertical counter rV:
  - Range 0..V_TOTAL-1, where V_TOTAL = 525.
  - Wraps to 0 at rH=799, rV=524.
- Visible region: rH<H_VISIBLE and rV<V_VISIBLE.
- Address generation:
  - oReadAddress is a registered linear counter, not a multiplier.
  - It increments by 1 on each tick where the current position is visible.
  - It clears to 0 on the tick that wraps to (0,0).
  - It holds during blanking. It therefore always equals rV*640+rH for visible positions.
  - Maximum value is 307199; upper bits are zero.
- Output pipeline (one pixel tick latency):
  - On each tick, the outputs capture the state of the position just left.
  - oVGA_HSYNC = 0 iff rH in [656,751].
  - oVGA_VSYNC = 0 iff rV in [490,491].
  - RGB = iReadData if the position was visible, else 000.
  - Memory must return data within 2 Clocks (one tick); a 1-Clock synchronous read meets this.
- oFrameStart: high for exactly one Clock, on the tick where the counters wrap to (0,0).
- Sync/data alignment: HSYNC, VSYNC and RGB always change on the same Clock edge.
- Reset mid-frame: all state returns to reset values immediately. Scanning restarts at (0,0) after release, with no partial-line artefacts beyond the truncated frame.
- Read-only block: iReadData is ignored during blanking, and the block never writes memory.

Optional Feature:
- Macro: VGA_TEST_PATTERN_EN
- Defined:
  - Adds input port iTestPattern (1 bit).
  - When iTestPattern=1, visible RGB = rH[8:6] (eight vertical colour bars, 64 px wide). iReadData is ignored, but addresses still advance.
  - iTestPattern is sampled per tick.
- Not defined: port absent; RGB always comes from iReadData.

Test Plan:
- Reset held low 10 Clocks, then released:
  - all outputs at reset values while low.
  - first oFrameStart seen 2*800*525 = 840000 Clocks after the first tick.
- Line timing: measure HSYNC.
  - low for 192 Clocks (96 ticks).
  - period 1600 Clocks.
  - falling edge 2*(656+1) Clocks after a line's first tick.
- Frame timing: measure VSYNC.
  - low for 2 lines (3200 Clocks).
  - period 840000 Clocks.
- Memory model returns address[2:0] with 1-Clock latency:
  - pixel (x=5, y=0) outputs RGB=101.
  - pixel (x=639, y=479) requests address 307199 and outputs 111.
  - RGB=000 throughout blanking.
- Address bookkeeping:
  - oReadAddress holds 640 during the blanking after line 0.
  - oReadAddress returns to 0 at oFrameStart.
- Reset asserted at rH=300, rV=200, for 3 Clocks:
  - outputs return to reset values asynchronously.
  - oReadAddress=0.
  - next visible pixel requested is address 0.
- (VGA_TEST_PATTERN_EN) iTestPattern=1:
  - x=0..63 gives RGB 000; x=64 gives 001; x=448 gives 111.
  - blanking remains 000.
